// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional stall-cycle counter (Stall_Count port) is built only when STALL_CNT_EN is defined.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IF_Req,
    input  logic [31:0] IF_Addr,
    output logic [31:0] IF_Instr,
    output logic        IF_Valid,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_ReadData2,
    output logic [31:0] MEM_ReadData,
    output logic        MEM_Done,
    output logic        Stall_IF,
    output logic        Stall_MEM,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    input  logic [31:0] Mem_RData,
    input  logic        Mem_Ack
`ifdef STALL_CNT_EN
   ,output logic [31:0] Stall_Count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        mem_done_q, mem_done_d;

    logic        data_pending;
    logic        fetch_pending;

    // A request that has just completed is masked for its done cycle so it is never re-issued.
    assign data_pending  = (MEM_MemRead | MEM_MemWrite) & ~mem_done_q;
    assign fetch_pending = IF_Req & ~if_valid_q;

    assign Stall_MEM = rst_n & data_pending;
    assign Stall_IF  = rst_n & (fetch_pending | data_pending);

    assign IF_Instr     = if_instr_q;
    assign IF_Valid     = if_valid_q;
    assign MEM_ReadData = mem_rdata_q;
    assign MEM_Done     = mem_done_q;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        if_instr_d  = if_instr_q;
        if_valid_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;
        Mem_Req     = 1'b0;
        Mem_We      = 1'b0;
        Mem_Addr    = 32'd0;
        Mem_WData   = 32'd0;

        case (state_q)
            IDLE: begin
                // Data wins ties unless data was served last, which keeps fetch from starving.
                if (data_pending && (!fetch_pending || !last_data_q)) begin
                    state_d = DACC;
                end else if (fetch_pending) begin
                    state_d = IACC;
                end
            end
            DACC: begin
                Mem_Req   = 1'b1;
                Mem_We    = MEM_MemWrite;
                Mem_Addr  = MEM_ALUResult;
                Mem_WData = MEM_ReadData2;
                if (Mem_Ack) begin
                    if (!MEM_MemWrite) begin
                        mem_rdata_d = Mem_RData;
                    end
                    mem_done_d  = 1'b1;
                    last_data_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IACC: begin
                Mem_Req  = 1'b1;
                Mem_Addr = IF_Addr;
                if (Mem_Ack) begin
                    if_instr_d  = Mem_RData;
                    if_valid_d  = 1'b1;
                    last_data_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            if_instr_q  <= 32'd0;
            if_valid_q  <= 1'b0;
            mem_rdata_q <= 32'd0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (Stall_IF && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign Stall_Count = stall_count_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers Mem_Req after ack_delay cycles,
// expected fetch/load results are queued at stimulus time and popped when IF_Valid/MEM_Done pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IF_Req = 1'b0;
    logic [31:0] IF_Addr = 32'd0;
    logic [31:0] IF_Instr;
    logic        IF_Valid;
    logic        MEM_MemRead = 1'b0;
    logic        MEM_MemWrite = 1'b0;
    logic [31:0] MEM_ALUResult = 32'd0;
    logic [31:0] MEM_ReadData2 = 32'd0;
    logic [31:0] MEM_ReadData;
    logic        MEM_Done;
    logic        Stall_IF;
    logic        Stall_MEM;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [31:0] Mem_RData = 32'd0;
    logic        Mem_Ack = 1'b0;
`ifdef STALL_CNT_EN
    logic [31:0] Stall_Count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_if_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] mem_model[logic [31:0]];
    logic [31:0] last_load_val = 32'd0;

    int   ack_delay = 1;
    int   req_cnt = 0;
    bit   force_ack = 1'b0;
    logic prev_req = 1'b0;

    mem_port_arbiter dut (
`ifdef STALL_CNT_EN
        .Stall_Count   (Stall_Count),
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .IF_Req        (IF_Req),
        .IF_Addr       (IF_Addr),
        .IF_Instr      (IF_Instr),
        .IF_Valid      (IF_Valid),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_MemWrite  (MEM_MemWrite),
        .MEM_ALUResult (MEM_ALUResult),
        .MEM_ReadData2 (MEM_ReadData2),
        .MEM_ReadData  (MEM_ReadData),
        .MEM_Done      (MEM_Done),
        .Stall_IF      (Stall_IF),
        .Stall_MEM     (Stall_MEM),
        .Mem_Req       (Mem_Req),
        .Mem_We        (Mem_We),
        .Mem_Addr      (Mem_Addr),
        .Mem_WData     (Mem_WData),
        .Mem_RData     (Mem_RData),
        .Mem_Ack       (Mem_Ack)
    );

    always #5 clk = ~clk;

    // Behavioural memory: acks on the ack_delay-th cycle of a request and logs every new grant address.
    always @(negedge clk) begin
        if (Mem_Req) begin
            req_cnt = req_cnt + 1;
            if (!prev_req) grant_log.push_back(Mem_Addr);
        end else begin
            req_cnt = 0;
        end
        prev_req = Mem_Req;
        Mem_Ack = force_ack || (Mem_Req && (req_cnt == ack_delay));
        if (Mem_Req && Mem_Ack && Mem_We) mem_model[Mem_Addr] = Mem_WData;
        if (Mem_Req && mem_model.exists(Mem_Addr)) Mem_RData = mem_model[Mem_Addr];
        else if (force_ack) Mem_RData = 32'hBAD0_0ACC;
        else Mem_RData = 32'h0;
    end

    logic [31:0] sb_exp;
    always @(negedge clk) begin
        if (IF_Valid) begin
            checks++;
            if (exp_if_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_if_unexpected: IF_Valid with IF_Instr=%h, none expected", IF_Instr);
            end else begin
                sb_exp = exp_if_q.pop_front();
                if (IF_Instr !== sb_exp) begin
                    errors++;
                    $display("[TB] FAIL sb_if_instr: got %h expected %h", IF_Instr, sb_exp);
                end
            end
        end
        if (MEM_Done) begin
            checks++;
            if (exp_data_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_data_unexpected: MEM_Done with MEM_ReadData=%h, none expected", MEM_ReadData);
            end else begin
                sb_exp = exp_data_q.pop_front();
                if (MEM_ReadData !== sb_exp) begin
                    errors++;
                    $display("[TB] FAIL sb_mem_readdata: got %h expected %h", MEM_ReadData, sb_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] val, input int delay, output bit ok);
        bit seen = 1'b0;
        ack_delay = delay;
        mem_model[addr] = val;
        exp_data_q.push_back(val);
        last_load_val = val;
        MEM_ALUResult = addr;
        MEM_MemRead = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (MEM_Done) seen = 1'b1;
            tick();
        end
        MEM_MemRead = 1'b0;
        ok = seen;
    endtask

    task automatic test_reset();
        logic [230:0] outs;
        rst_n = 1'b0;
        repeat (2) tick();
        outs = {IF_Instr, IF_Valid, MEM_ReadData, MEM_Done, Stall_IF, Stall_MEM,
                Mem_Req, Mem_We, Mem_Addr, Mem_WData, 32'd0, 32'd0, 1'b0};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
        IF_Req = 1'b1;
        MEM_MemRead = 1'b1;
        #1;
        checks++;
        if ({Stall_IF, Stall_MEM, Mem_Req} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_stalls_forced: got %b expected 000", {Stall_IF, Stall_MEM, Mem_Req});
        end
`ifdef STALL_CNT_EN
        checks++;
        if (Stall_Count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_count: got %h expected 0", Stall_Count);
        end
`endif
        IF_Req = 1'b0;
        MEM_MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        int st = 0;
        int vc = 0;
        int bad = 0;
        bit seen = 1'b0;
        ack_delay = 1;
        mem_model[32'h0040_0000] = 32'h8C08_0004;
        exp_if_q.push_back(32'h8C08_0004);
        IF_Addr = 32'h0040_0000;
        IF_Req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Stall_IF) st++;
            if (IF_Valid) begin
                vc++;
                seen = 1'b1;
            end
            if (Mem_Req && (Mem_We !== 1'b0 || Mem_Addr !== 32'h0040_0000)) bad++;
            tick();
            if (seen) IF_Req = 1'b0;
        end
        checks++;
        if (vc != 1) begin
            errors++;
            $display("[TB] FAIL fetch_valid_pulses: got %0d expected 1", vc);
        end
        checks++;
        if (st != 2) begin
            errors++;
            $display("[TB] FAIL fetch_stall_if_cycles: got %0d expected 2", st);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL fetch_mem_bus: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int di = 0;
        int fi = 0;
        int g0;
        bit dn;
        bit fv;
        logic [31:0] want[4];
        for (int k = 0; k < 2; k++) begin
            mem_model[32'h1002_0000 + 32'(4 * k)] = 32'hD000_0000 + 32'(k);
            mem_model[32'h0040_0100 + 32'(4 * k)] = 32'hF000_0000 + 32'(k);
            exp_data_q.push_back(32'hD000_0000 + 32'(k));
            exp_if_q.push_back(32'hF000_0000 + 32'(k));
        end
        want[0] = 32'h1002_0000;
        want[1] = 32'h0040_0100;
        want[2] = 32'h1002_0004;
        want[3] = 32'h0040_0104;
        last_load_val = 32'hD000_0001;
        ack_delay = 1;
        g0 = grant_log.size();
        MEM_ALUResult = 32'h1002_0000;
        MEM_MemRead = 1'b1;
        IF_Addr = 32'h0040_0100;
        IF_Req = 1'b1;
        for (int i = 0; i < 40 && (di < 2 || fi < 2); i++) begin
            @(negedge clk);
            dn = MEM_Done;
            fv = IF_Valid;
            tick();
            if (dn) begin
                di++;
                if (di < 2) MEM_ALUResult = 32'h1002_0000 + 32'(4 * di);
                else MEM_MemRead = 1'b0;
            end
            if (fv) begin
                fi++;
                if (fi < 2) IF_Addr = 32'h0040_0100 + 32'(4 * fi);
                else IF_Req = 1'b0;
            end
        end
        MEM_MemRead = 1'b0;
        IF_Req = 1'b0;
        checks++;
        if (di != 2 || fi != 2) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: got %0d data %0d fetch done expected 2 and 2", di, fi);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (grant_log.size() <= g0 + k) begin
                errors++;
                $display("[TB] FAIL b2b_grant_%0d: no grant expected %h", k, want[k]);
            end else if (grant_log[g0 + k] !== want[k]) begin
                errors++;
                $display("[TB] FAIL b2b_grant_%0d: got %h expected %h", k, grant_log[g0 + k], want[k]);
            end
        end
    endtask

    task automatic test_load();
        int st = 0;
        int dc = 0;
        int bad = 0;
        int g0;
        bit seen = 1'b0;
        ack_delay = 3;
        mem_model[32'h1001_0000] = 32'hDEAD_BEEF;
        exp_data_q.push_back(32'hDEAD_BEEF);
        last_load_val = 32'hDEAD_BEEF;
        g0 = grant_log.size();
        MEM_ALUResult = 32'h1001_0000;
        MEM_MemRead = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (Stall_MEM) st++;
            if (MEM_Done) begin
                dc++;
                seen = 1'b1;
            end
            if (Mem_Req && (Mem_We !== 1'b0 || Mem_Addr !== 32'h1001_0000)) bad++;
            tick();
            if (seen) MEM_MemRead = 1'b0;
        end
        checks++;
        if (dc != 1) begin
            errors++;
            $display("[TB] FAIL load_done_pulses: got %0d expected 1", dc);
        end
        checks++;
        if (st != 4) begin
            errors++;
            $display("[TB] FAIL load_stall_mem_cycles: got %0d expected 4", st);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL load_mem_bus: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (grant_log.size() - g0 != 1) begin
            errors++;
            $display("[TB] FAIL load_issue_count: got %0d expected 1", grant_log.size() - g0);
        end
    endtask

    task automatic test_priority();
        int g0;
        bit dseen = 1'b0;
        bit fseen = 1'b0;
        ack_delay = 1;
        mem_model[32'h0040_0010] = 32'h1111_1111;
        mem_model[32'h1001_0008] = 32'h2222_2222;
        exp_if_q.push_back(32'h1111_1111);
        exp_data_q.push_back(32'h2222_2222);
        last_load_val = 32'h2222_2222;
        g0 = grant_log.size();
        IF_Addr = 32'h0040_0010;
        MEM_ALUResult = 32'h1001_0008;
        IF_Req = 1'b1;
        MEM_MemRead = 1'b1;
        for (int i = 0; i < 20 && !(dseen && fseen); i++) begin
            @(negedge clk);
            if (MEM_Done) dseen = 1'b1;
            if (IF_Valid) fseen = 1'b1;
            tick();
            if (dseen) MEM_MemRead = 1'b0;
            if (fseen) IF_Req = 1'b0;
        end
        MEM_MemRead = 1'b0;
        IF_Req = 1'b0;
        checks++;
        if (grant_log.size() - g0 != 2) begin
            errors++;
            $display("[TB] FAIL prio_grant_count: got %0d expected 2", grant_log.size() - g0);
        end else if (grant_log[g0] !== 32'h0040_0010 || grant_log[g0 + 1] !== 32'h1001_0008) begin
            errors++;
            $display("[TB] FAIL prio_order: got %h,%h expected 00400010,10010008", grant_log[g0], grant_log[g0 + 1]);
        end
    endtask

    task automatic test_store();
        int rc = 0;
        int bad = 0;
        bit seen = 1'b0;
        ack_delay = 2;
        mem_model[32'h1001_0004] = 32'hA5A5_A5A5;
        exp_data_q.push_back(last_load_val);
        MEM_ALUResult = 32'h1001_0004;
        MEM_ReadData2 = 32'h1234_5678;
        MEM_MemWrite = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Mem_Req) begin
                rc++;
                if (Mem_We !== 1'b1 || Mem_Addr !== 32'h1001_0004 || Mem_WData !== 32'h1234_5678) bad++;
            end
            if (MEM_Done) seen = 1'b1;
            tick();
            if (seen) MEM_MemWrite = 1'b0;
        end
        MEM_ReadData2 = 32'd0;
        checks++;
        if (!seen || rc != 2) begin
            errors++;
            $display("[TB] FAIL store_req_cycles: got %0d (done=%0d) expected 2 (done=1)", rc, seen);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL store_bus_stable: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (mem_model[32'h1001_0004] !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL store_written: got %h expected 12345678", mem_model[32'h1001_0004]);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [230:0] outs;
        int bad = 0;
        bit got = 1'b0;
        ack_delay = 5;
        mem_model[32'h1003_0000] = 32'h3333_3333;
        MEM_ALUResult = 32'h1003_0000;
        MEM_MemRead = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (Mem_Req) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL rstmid_no_grant: got Mem_Req=0 expected 1");
        end
        rst_n = 1'b0;
        #1;
        outs = {IF_Instr, IF_Valid, MEM_ReadData, MEM_Done, Stall_IF, Stall_MEM,
                Mem_Req, Mem_We, Mem_Addr, Mem_WData, 32'd0, 32'd0, 1'b0};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got %h expected 0", outs);
        end
        tick();
        MEM_MemRead = 1'b0;
        rst_n = 1'b1;
        last_load_val = 32'd0;
        force_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (Mem_Req !== 1'b0 || MEM_Done !== 1'b0 || IF_Valid !== 1'b0 || MEM_ReadData !== 32'd0) bad++;
        end
        force_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_ack_ignored: got %0d bad cycles expected 0", bad);
        end
    endtask

`ifdef STALL_CNT_EN
    task automatic test_stall_count();
        bit ok1;
        bit ok2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_load(32'h1004_0000, 32'h4444_0000, 2, ok1);
        do_load(32'h1004_0004, 32'h4444_0004, 3, ok2);
        checks++;
        if (!ok1 || !ok2 || Stall_Count !== 32'd7) begin
            errors++;
            $display("[TB] FAIL stall_count_seven: got %h expected 00000007", Stall_Count);
        end
        force dut.stall_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.stall_count_q;
        tick();
        do_load(32'h1004_0008, 32'h4444_0008, 2, ok1);
        checks++;
        if (!ok1 || Stall_Count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL stall_count_saturate: got %h expected FFFFFFFF", Stall_Count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_load();
        test_priority();
        test_store();
        test_reset_mid_access();
`ifdef STALL_CNT_EN
        test_stall_count();
`endif
        repeat (2) tick();
        checks++;
        if (exp_if_q.size() != 0 || exp_data_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover: got %0d fetch %0d data pending expected 0", exp_if_q.size(), exp_data_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- IF_Req  in  1  fetch request; held until IF_Valid
- IF_Addr  in  32  fetch address
- IF_Instr  out  32  fetched word; valid when IF_Valid=1
- IF_Valid  out  1  one-cycle fetch-complete pulse
- MEM_MemRead  in  1  data load request from the EX/MEM register
- MEM_MemWrite  in  1  data store request from the EX/MEM register
- MEM_ALUResult  in  32  data address
- MEM_ReadData2  in  32  store data
- MEM_ReadData  out  32  load result; valid when MEM_Done=1
- MEM_Done  out  1  one-cycle data-complete pulse
- Stall_IF  out  1  freeze PC and IF/ID
- Stall_MEM  out  1  freeze the entire pipeline, including EX/MEM
- Mem_Req  out  1  memory request; held until Mem_Ack
- Mem_We  out  1  1 = write
- Mem_Addr  out  32  memory address
- Mem_WData  out  32  memory write data
- Mem_RData  in  32  memory read data; valid with Mem_Ack
- Mem_Ack  in  1  memory completion; may take 1..N cycles after Mem_Req
- Stall_Count  out  32  stall-cycle counter; present only with STALL_CNT_EN

Function
REQ-002 The block SHALL share one single-ported memory between instruction fetch and data access.
REQ-003 The FSM SHALL have exactly three states: IDLE, DACC and IACC.
REQ-004 A data request is pending when (MEM_MemRead | MEM_MemWrite) = 1 and MEM_Done = 0.
REQ-005 A fetch request is pending when IF_Req = 1 and IF_Valid = 0.
REQ-006 IDLE arbitration SHALL work as follows:
- only data pending -> DACC
- only fetch pending -> IACC
- both pending -> DACC, unless the last completed access was data, in which case -> IACC
- This alternation rule prevents starvation.
REQ-007 In DACC, Mem_Req SHALL be 1, and the memory outputs SHALL be driven from the current inputs:
- Mem_We = MEM_MemWrite
- Mem_Addr = MEM_ALUResult
- Mem_WData = MEM_ReadData2
REQ-008 In IACC, Mem_Req SHALL be 1, Mem_We SHALL be 0 and Mem_Addr SHALL be IF_Addr.
REQ-009 In IDLE, Mem_Req, Mem_We, Mem_Addr and Mem_WData SHALL all be 0.
REQ-010 On a clock edge in DACC with Mem_Ack = 1, the block SHALL:
- register MEM_ReadData <= Mem_RData (loads only; stores leave MEM_ReadData unchanged)
- pulse MEM_Done for one cycle
- return to IDLE
REQ-011 On a clock edge in IACC with Mem_Ack = 1, the block SHALL register IF_Instr <= Mem_RData, pulse IF_Valid for one cycle and return to IDLE.
REQ-012 Minimum access latency SHALL be 2 cycles from request to done pulse: the grant edge, then the edge where Mem_Ack = 1.
REQ-013 Stall_MEM SHALL equal "data pending" combinationally.
REQ-014 Stall_IF SHALL equal (fetch pending) | Stall_MEM combinationally.
REQ-015 In the cycle MEM_Done = 1, the same access SHALL NOT be re-issued; the next instruction's access is arbitrated from the following cycle.
REQ-016 Mem_Req, Mem_We, Mem_Addr and Mem_WData SHALL remain stable until Mem_Ack; a Mem_Ack received in IDLE SHALL be ignored.
REQ-017 If MEM_MemRead and MEM_MemWrite are both 1, the access SHALL be treated as a write.

Reset
REQ-018 While rst_n = 0, the block SHALL immediately (asynchronously) force:
- state = IDLE
- all outputs = 0
- Stall_Count = 0
- last-completed-access flag = fetch
REQ-019 A reset asserted mid-access SHALL drop Mem_Req in the same cycle; the access is abandoned and not replayed.
REQ-020 After reset deasserts, the first arbitration SHALL occur on the first rising clk edge.

Configuration
REQ-021 With macro STALL_CNT_EN defined:
- Stall_Count increments on every clk edge where Stall_IF | Stall_MEM = 1
- it saturates at 32'hFFFFFFFF
- it clears only on reset
REQ-022 Without STALL_CNT_EN, the Stall_Count port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
- Fetch IF_Addr=0x00400000, memory acks 1 cycle after Mem_Req with 0x8C080004 -> IF_Instr=0x8C080004, IF_Valid high for exactly 1 cycle, Stall_IF high for exactly 2 cycles.
- Load, MEM_ALUResult=0x10010000, Mem_Ack after 3 cycles with 0xDEADBEEF -> Mem_We=0, MEM_ReadData=0xDEADBEEF, single MEM_Done pulse, Stall_MEM high for exactly 4 cycles, no re-issue.
- Store, address 0x10010004, data 0x12345678 -> Mem_We=1, Mem_WData=0x12345678 held stable until ack, MEM_ReadData unchanged.
- Fetch and data both pending continuously over 4 accesses -> grant order DACC, IACC, DACC, IACC.
- rst_n pulled low 1 cycle into DACC -> Mem_Req=0 the same cycle, all outputs 0, state IDLE; the subsequent Mem_Ack is ignored.
- With STALL_CNT_EN, 2 stalled accesses of 3 and 4 stall cycles -> Stall_Count=7; force the count to 0xFFFFFFFE and run 3 stall cycles -> Stall_Count=0xFFFFFFFF.
